// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester channels and uart_tx pull interface for uart_tx_arbiter
interface uart_tx_arbiter_if #(parameter int N_PORTS = 4);
  logic [N_PORTS-1:0]         req_valid_i;
  logic [N_PORTS-1:0][7:0]    req_data_i;
  logic [N_PORTS-1:0]         req_last_i;
  logic [N_PORTS-1:0]         req_ready_o;
  logic                       read_enable_i;
  logic [7:0]                 read_data_o;
  logic                       read_valid_o;
  logic [$clog2(N_PORTS)-1:0] grant_o;
  logic                       busy_o;
  modport master (
    output req_valid_i, req_data_i, req_last_i, read_enable_i,
    input  req_ready_o, read_data_o, read_valid_o, grant_o, busy_o
  );
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, read_enable_i,
    output req_ready_o, read_data_o, read_valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding uart_tx's pull interface.
// Define UART_TX_ARB_LOCK_EN to hold the grant on one port until its req_last_i byte.
module uart_tx_arbiter #(parameter int N_PORTS = 4) (
  input logic              clk_i,
  input logic              rst_ni,
  uart_tx_arbiter_if.slave bus
);
  localparam int W = $clog2(N_PORTS);
  typedef enum logic [1:0] {EMPTY, FULL, ISSUE, GUARD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, sel;
  logic [7:0] hold_q, hold_d;
  logic read_valid_q, found;
  logic [W:0] k;
  logic [N_PORTS-1:0] ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_last;
  assign unused_last = ^bus.req_last_i;
`endif
  // lowest offset from rr_ptr wins, so scan offsets downward and let later hits overwrite
  always_comb begin
    sel = rr_ptr_q;
    found = 1'b0;
    k = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      k = {1'b0, rr_ptr_q} + (W+1)'(i);
      k = (k >= (W+1)'(N_PORTS)) ? k - (W+1)'(N_PORTS) : k;
      if (bus.req_valid_i[k[W-1:0]]) begin
        sel = k[W-1:0];
        found = 1'b1;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_q) begin
      sel = grant_q;
      found = bus.req_valid_i[grant_q];
    end
`endif
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    hold_d = hold_q;
    ready = '0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d = lock_q;
`endif
    case (state_q)
      EMPTY: if (found) begin
        ready[sel] = 1'b1;
        hold_d = bus.req_data_i[sel];
        grant_d = sel;
        rr_ptr_d = (sel == W'(N_PORTS - 1)) ? '0 : sel + 1'b1;
        state_d = FULL;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d = !bus.req_last_i[sel];
`endif
      end
      FULL: state_d = bus.read_enable_i ? ISSUE : FULL;
      ISSUE: state_d = GUARD;
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rr_ptr_q <= '0;
      grant_q <= '0;
      hold_q <= 8'h00;
      read_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      hold_q <= hold_d;
      read_valid_q <= (state_d == ISSUE);
    end
  end
`ifdef UART_TX_ARB_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= 1'b0;
    else lock_q <= lock_d;
  end
`endif
  // ready must stay quiet while reset holds the FSM, even with requesters valid
  assign bus.req_ready_o = rst_ni ? ready : '0;
  assign bus.read_data_o = hold_q;
  assign bus.read_valid_o = read_valid_q;
  assign bus.grant_o = grant_q;
  assign bus.busy_o = (state_q != EMPTY);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus corner-case sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  uart_tx_arbiter_if #(.N_PORTS(4)) bus();
  uart_tx_arbiter #(.N_PORTS(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        re;
    logic [3:0]  rdy;
    logic        rv;
    logic [7:0]  rd;
    logic [1:0]  g;
    logic        b;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] last, input logic re);
    bus.req_valid_i = v;
    bus.req_data_i = d;
    bus.req_last_i = last;
    bus.read_enable_i = re;
  endtask
  localparam logic [31:0] D = 32'h13121110;
  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_lock[4];
    int last_pulse, min_gap, pulses, idx2, cyc;
    bit ok;
    // single port 0, then all four ports round-robin starting from rr_ptr=1
    tbl.push_back('{4'h1, 32'h41, 1, 4'h0 | 4'h1, 0, 8'h00, 2'd0, 0});
    tbl.push_back('{4'h0, 32'h0,  1, 4'h0, 0, 8'h41, 2'd0, 1});
    tbl.push_back('{4'h0, 32'h0,  1, 4'h0, 1, 8'h41, 2'd0, 1});
    tbl.push_back('{4'h0, 32'h0,  0, 4'h0, 0, 8'h41, 2'd0, 1});
    tbl.push_back('{4'h0, 32'h0,  1, 4'h0, 0, 8'h41, 2'd0, 0});
    tbl.push_back('{4'hF, D, 1, 4'h2, 0, 8'h41, 2'd0, 0});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h11, 2'd1, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 1, 8'h11, 2'd1, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h11, 2'd1, 1});
    tbl.push_back('{4'hF, D, 1, 4'h4, 0, 8'h11, 2'd1, 0});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h12, 2'd2, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 1, 8'h12, 2'd2, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h12, 2'd2, 1});
    tbl.push_back('{4'hF, D, 1, 4'h8, 0, 8'h12, 2'd2, 0});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h13, 2'd3, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 1, 8'h13, 2'd3, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h13, 2'd3, 1});
    tbl.push_back('{4'hF, D, 1, 4'h1, 0, 8'h13, 2'd3, 0});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h10, 2'd0, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 1, 8'h10, 2'd0, 1});
    tbl.push_back('{4'hF, D, 1, 4'h0, 0, 8'h10, 2'd0, 1});
    tbl.push_back('{4'h0, D, 1, 4'h0, 0, 8'h10, 2'd0, 0});
    drive(4'h0, 32'h0, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rv", 32'(bus.read_valid_o), 32'd0);
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_rdata", 32'(bus.read_data_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, 4'hF, tbl[i].re);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(bus.req_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_rv", i), 32'(bus.read_valid_o), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rd", i), 32'(bus.read_data_o), 32'(tbl[i].rd));
      chk($sformatf("v%0d_grant", i), 32'(bus.grant_o), 32'(tbl[i].g));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].b));
      step();
    end
    // back-pressure: byte held in FULL for 100 cycles
    drive(4'h1, 32'h55, 4'hF, 1'b0);
    #1;
    chk("bp_ready", 32'(bus.req_ready_o), 32'h1);
    step();
    drive(4'h0, 32'h0, 4'hF, 1'b0);
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.read_valid_o !== 1'b0 || bus.req_ready_o !== 4'h0 || bus.busy_o !== 1'b1 || bus.read_data_o !== 8'h55) ok = 0;
      step();
    end
    chk("bp_hold", 32'(ok), 32'd1);
    bus.read_enable_i = 1'b1;
    #1;
    chk("bp_rv_before", 32'(bus.read_valid_o), 32'd0);
    step();
    chk("bp_rv", 32'(bus.read_valid_o), 32'd1);
    chk("bp_rd", 32'(bus.read_data_o), 32'h55);
    step();
    chk("bp_rv_guard", 32'(bus.read_valid_o), 32'd0);
    step();
    chk("bp_rv_empty", 32'(bus.read_valid_o), 32'd0);
    chk("bp_busy_empty", 32'(bus.busy_o), 32'd0);
    // guard spacing with ports 1 and 2 continuously valid
    drive(4'h6, 32'h00222100, 4'hF, 1'b1);
    last_pulse = -100;
    min_gap = 1000;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.read_valid_o === 1'b1) begin
        if (c - last_pulse < min_gap) min_gap = c - last_pulse;
        last_pulse = c;
        chk($sformatf("guard_rd%0d", pulses), 32'(bus.read_data_o), (pulses % 2 == 0) ? 32'h21 : 32'h22);
        pulses++;
      end
      step();
    end
    chk("guard_pulses", 32'(pulses), 32'd10);
    chk("guard_min_gap", 32'(min_gap), 32'd4);
    drive(4'h0, 32'h0, 4'hF, 1'b0);
    step();
    step();
    step();
    // reset while FULL: held byte is dropped, never pulsed
    drive(4'h8, 32'h33000000, 4'hF, 1'b0);
    #1;
    chk("mid_ready", 32'(bus.req_ready_o), 32'h8);
    step();
    drive(4'hF, 32'h33000000, 4'hF, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_grant", 32'(bus.grant_o), 32'd0);
    chk("mid_rd", 32'(bus.read_data_o), 32'd0);
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.read_valid_o !== 1'b0 || bus.req_ready_o !== 4'h0) ok = 0;
    end
    chk("mid_quiet", 32'(ok), 32'd1);
    rst_n = 1'b1;
    drive(4'h0, 32'h0, 4'hF, 1'b1);
    #1;
    chk("post_ready_idle", 32'(bus.req_ready_o), 32'h0);
    chk("post_rv", 32'(bus.read_valid_o), 32'd0);
    step();
    drive(4'hF, 32'h03020130, 4'hF, 1'b1);
    #1;
    chk("post_ready_p0", 32'(bus.req_ready_o), 32'h1);
    step();
    drive(4'h0, 32'h0, 4'hF, 1'b1);
    #1;
    chk("post_grant", 32'(bus.grant_o), 32'd0);
    chk("post_rd", 32'(bus.read_data_o), 32'h30);
    step();
    chk("post_pulse", 32'(bus.read_valid_o), 32'd1);
    step();
    step();
    // port 2 message of three bytes competing with port 0
`ifdef UART_TX_ARB_LOCK_EN
    exp_lock = '{8'hA0, 8'hA1, 8'hA2, 8'h0A};
`else
    exp_lock = '{8'hA0, 8'h0A, 8'hA1, 8'h0A};
`endif
    idx2 = 0;
    cyc = 0;
    while (got.size() < 4 && cyc < 60) begin
      drive({1'b0, idx2 < 3, 1'b0, 1'b1}, {8'h00, 8'hA0 + 8'(idx2), 8'h00, 8'h0A},
            {1'b1, idx2 == 2, 1'b1, 1'b1}, 1'b1);
      #1;
      if (bus.req_ready_o[2] && bus.req_valid_i[2]) idx2++;
      if (bus.read_valid_o === 1'b1) got.push_back(bus.read_data_o);
      cyc++;
      step();
    end
    chk("lock_pulses", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("lock_byte%0d", i), 32'(got[i]), 32'(exp_lock[i]));
    drive(4'h0, 32'h0, 4'hF, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
